// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional feature macro used by the top: MULT_SEQ_EARLY_EXIT_EN.
package mult_pkg;

  // Working width of the magnitude helper; operand widths must stay below this.
  localparam int MAG_W = 64;

  typedef logic [1:0] state_t;

  typedef enum state_t {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  // Two's-complement magnitude of a zero-extended operand. The caller keeps only
  // the operand-width low bits, so -2^(W-1) maps to 2^(W-1) as an unsigned value.
  function automatic logic [MAG_W-1:0] twos_mag(input logic [MAG_W-1:0] x,
                                                input logic              is_neg);
    return is_neg ? (~x + MAG_W'(1)) : x;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add multiply step: conditionally accumulate the shifted
// multiplicand, then advance both shift registers by one bit.
module mult_step #(
  parameter int P_W = 24,
  parameter int B_W = 8
) (
  input  logic [P_W-1:0] acc,
  input  logic [P_W-1:0] a_sh,
  input  logic [B_W-1:0] b_sh,
  output logic [P_W-1:0] acc_next,
  output logic [P_W-1:0] a_sh_next,
  output logic [B_W-1:0] b_sh_next
);

  // Single iteration of the classic add-then-shift recurrence.
  always_comb begin
    acc_next  = b_sh[0] ? (acc + a_sh) : acc;
    a_sh_next = a_sh << 1;
    b_sh_next = b_sh >> 1;
  end

endmodule

// File: rtl/mult_seq_shift_add.sv
// Iterative shift-add multiplier, one multiplier bit per clock, with
// valid/ready handshakes and optional two's-complement operation.
// Define MULT_SEQ_EARLY_EXIT_EN to finish as soon as the remaining multiplier
// bits are all zero; otherwise latency is a fixed B_W cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for operands, in_ready high
// ST_RUN  | iterating, one multiplier bit per clock, busy high
// ST_DONE | product presented, out_valid high until out_ready
module mult_seq_shift_add
  import mult_pkg::*;
#(
  parameter int A_W    = 16,
  parameter int B_W    = 8,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W+B_W-1:0]   product,
  output logic                 busy
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(B_W);

  mult_state_e      state;
  logic [P_W-1:0]   acc;
  logic [P_W-1:0]   a_sh;
  logic [B_W-1:0]   b_sh;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic [P_W-1:0]   acc_next;
  logic [P_W-1:0]   a_sh_next;
  logic [B_W-1:0]   b_sh_next;
  logic             last;

  logic             a_neg;
  logic             b_neg;
  logic [MAG_W-1:0] a_mag_w;
  logic [MAG_W-1:0] b_mag_w;
  logic             unused_mag_bits;

  assign a_neg   = (SIGNED != 0) && a[A_W-1];
  assign b_neg   = (SIGNED != 0) && b[B_W-1];
  assign a_mag_w = twos_mag(MAG_W'(a), a_neg);
  assign b_mag_w = twos_mag(MAG_W'(b), b_neg);
  // Only the operand-width magnitudes are meaningful.
  assign unused_mag_bits = ^{a_mag_w[MAG_W-1:A_W], b_mag_w[MAG_W-1:B_W]};

  mult_step #(.P_W(P_W), .B_W(B_W)) u_step (
    .acc       (acc),
    .a_sh      (a_sh),
    .b_sh      (b_sh),
    .acc_next  (acc_next),
    .a_sh_next (a_sh_next),
    .b_sh_next (b_sh_next)
  );

`ifdef MULT_SEQ_EARLY_EXIT_EN
  assign last = (cnt == CNT_W'(B_W - 1)) || (b_sh_next == '0);
`else
  assign last = (cnt == CNT_W'(B_W - 1));
`endif

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign out_valid = (state == ST_DONE);

  // Handshake FSM and datapath registers; flush aborts without touching product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh  <= P_W'(a_mag_w[A_W-1:0]);
            b_sh  <= b_mag_w[B_W-1:0];
            acc   <= '0;
            cnt   <= '0;
            neg   <= a_neg ^ b_neg;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc  <= acc_next;
          a_sh <= a_sh_next;
          b_sh <= b_sh_next;
          cnt  <= cnt + CNT_W'(1);
          if (last) begin
            product <= neg ? (P_W'(0) - acc_next) : acc_next;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
